// File: rtl/bch_pkg.sv
// Shared definitions for the BCH encoder/decoder front-end controllers:
// FSM state encoding and requester count.
package bch_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LAUNCH  = 2'd2,
        ST_WAIT    = 2'd3
    } bch_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that was
// not granted last wins; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bch_enc_arbiter.sv
// Arbitrates two byte-stream requesters onto one shared BCH encoder: collects
// MSG_BYTES bytes from the granted owner, launches the encoder, waits for done.
module bch_enc_arbiter
    import bch_pkg::*;
#(
    parameter int MSG_BYTES = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [7:0]             req_data0,
    input  logic [7:0]             req_data1,
    output logic [1:0]             req_ready,
    output logic                   enc_start,
    output logic [MSG_BYTES*8-1:0] enc_msg,
    output logic                   enc_id,
    input  logic                   enc_done,
    output logic [1:0]             frame_done,
    output logic [1:0]             frame_abort
);

    localparam int W  = MSG_BYTES * 8;
    localparam int CW = $clog2(MSG_BYTES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    bch_state_t     state_reg, state_next;
    logic           owner_reg, owner_next;
    logic           last_reg, last_next;
    logic [CW-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [IW-1:0]  idle_cnt_reg, idle_cnt_next;
    logic [W-1:0]   msg_reg, msg_next;

    logic [1:0]     grant;
    logic [N_REQ-1:0] owner_onehot;
    logic [7:0]     owner_data;
    logic           accept;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (last_reg),
        .grant (grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_owner
            assign owner_onehot[gi] = (owner_reg == 1'(gi));
        end
    endgenerate

    assign owner_data = owner_reg ? req_data1 : req_data0;
    assign accept     = (state_reg == ST_COLLECT) && req_valid[owner_reg];
    assign enc_msg    = msg_reg;
    assign enc_id     = owner_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= 1'b0;
            last_reg     <= 1'b1;
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            msg_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            byte_cnt_reg <= byte_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            msg_reg      <= msg_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        byte_cnt_next = byte_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        msg_next      = msg_reg;
        req_ready     = 2'b00;
        enc_start     = 1'b0;
        frame_done    = 2'b00;
        frame_abort   = 2'b00;

        unique case (state_reg)
            ST_IDLE: begin
                // Grant only; the first byte is taken in COLLECT.
                if (|req_valid) begin
                    owner_next    = grant[1];
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                    state_next    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                req_ready = owner_onehot & req_valid;
                if (accept) begin
                    msg_next      = W'({msg_reg, owner_data});
                    idle_cnt_next = '0;
                    if (byte_cnt_reg == CW'(MSG_BYTES - 1)) begin
                        byte_cnt_next = '0;
                        state_next    = ST_LAUNCH;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end
                end else if (idle_cnt_reg == IW'(TIMEOUT - 1)) begin
                    frame_abort   = owner_onehot;
                    last_next     = owner_reg;
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            ST_LAUNCH: begin
                enc_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (enc_done) begin
                    frame_done = owner_onehot;
                    last_next  = owner_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A frame interrupted by reset leaves without any completion pulse.
        if (reset) begin
            req_ready   = 2'b00;
            enc_start   = 1'b0;
            frame_done  = 2'b00;
            frame_abort = 2'b00;
        end
    end

endmodule

// File: tb/tb_bch_enc_arbiter.sv
// Directed self-checking bench for bch_enc_arbiter: single requester,
// contention, timeout, stray done, mid-frame reset and stall scenarios.
module tb_bch_enc_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_data0;
    logic [7:0]  req_data1;
    logic [1:0]  req_ready;
    logic        enc_start;
    logic [23:0] enc_msg;
    logic        enc_id;
    logic        enc_done;
    logic [1:0]  frame_done;
    logic [1:0]  frame_abort;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    bch_enc_arbiter #(.MSG_BYTES(3), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .enc_start   (enc_start),
        .enc_msg     (enc_msg),
        .enc_id      (enc_id),
        .enc_done    (enc_done),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        enc_done  = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs one full frame starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic do_frame(input logic id, input logic [23:0] msg, input logic other_valid);
        logic [1:0] own;
        own = id ? 2'b10 : 2'b01;
        req_valid = own | (other_valid ? ~own : 2'b00);
        if (id) begin req_data1 = msg[23:16]; req_data0 = 8'h5A; end
        else    begin req_data0 = msg[23:16]; req_data1 = 8'h5A; end
        #1;
        tests_run++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL frame_idle_ready: got %b want 00", req_ready); end
        step();
        for (int k = 0; k < 3; k++) begin
            if (id) req_data1 = msg[23-8*k -: 8];
            else    req_data0 = msg[23-8*k -: 8];
            #1;
            tests_run++;
            if (req_ready !== own) begin fails++; $display("FAIL frame_ready byte%0d: got %b want %b", k, req_ready, own); end
            tests_run++;
            if (enc_start !== 1'b0) begin fails++; $display("FAIL frame_early_start byte%0d: got %b want 0", k, enc_start); end
            step();
        end
        req_valid = other_valid ? ~own : 2'b00;
        #1;
        tests_run++;
        if (enc_start !== 1'b1) begin fails++; $display("FAIL frame_start: got %b want 1", enc_start); end
        tests_run++;
        if (enc_msg !== msg) begin fails++; $display("FAIL frame_msg: got %h want %h", enc_msg, msg); end
        tests_run++;
        if (enc_id !== id) begin fails++; $display("FAIL frame_id: got %b want %b", enc_id, id); end
        tests_run++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL frame_launch_ready: got %b want 00", req_ready); end
        step();
        tests_run++;
        if (enc_start !== 1'b0) begin fails++; $display("FAIL frame_start_width: got %b want 0", enc_start); end
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== own) begin fails++; $display("FAIL frame_done: got %b want %b", frame_done, own); end
        tests_run++;
        if (enc_msg !== msg) begin fails++; $display("FAIL frame_msg_hold: got %h want %h", enc_msg, msg); end
        step();
        enc_done = 1'b0;
        #1;
        tests_run++;
        if (frame_done !== 2'b00) begin fails++; $display("FAIL frame_done_width: got %b want 00", frame_done); end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        tests_run++;
        if (enc_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", enc_start); end
        tests_run++;
        if (frame_done !== 2'b00 || frame_abort !== 2'b00) begin
            fails++; $display("FAIL reset_pulses: got done=%b abort=%b want 00/00", frame_done, frame_abort);
        end
        tests_run++;
        if (enc_msg !== 24'h0 || enc_id !== 1'b0) begin
            fails++; $display("FAIL reset_msg_id: got msg=%h id=%b want 000000/0", enc_msg, enc_id);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        apply_reset();
        do_frame(1'b0, 24'hABCDEF, 1'b0);
        $display("[TB] single requester frame ABCDEF");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_frame(1'b0, 24'h0A0B0C, 1'b1);
        do_frame(1'b1, 24'h1A1B1C, 1'b1);
        do_frame(1'b0, 24'h2A2B2C, 1'b1);
        req_valid = 2'b00;
        $display("[TB] contention grants 0,1,0");
    endtask

    task automatic test_timeout();
        apply_reset();
        req_valid = 2'b01;
        req_data0 = 8'h11;
        #1;
        step();
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL timeout_first_byte: got %b want 01", req_ready); end
        step();
        req_valid = 2'b10;
        req_data1 = 8'h99;
        for (int i = 1; i < 15; i++) begin
            #1;
            tests_run++;
            if (frame_abort !== 2'b00 || req_ready !== 2'b00) begin
                fails++; $display("FAIL timeout_early idle%0d: got abort=%b ready=%b want 00/00", i, frame_abort, req_ready);
            end
            step();
        end
        #1;
        tests_run++;
        if (frame_abort !== 2'b01) begin fails++; $display("FAIL timeout_abort: got %b want 01", frame_abort); end
        tests_run++;
        if (enc_start !== 1'b0) begin fails++; $display("FAIL timeout_start: got %b want 0", enc_start); end
        step();
        do_frame(1'b1, 24'h313233, 1'b1);
        req_valid = 2'b00;
        $display("[TB] timeout abort then grant to requester 1");
    endtask

    task automatic test_stray_done();
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== 2'b00) begin fails++; $display("FAIL stray_idle: got %b want 00", frame_done); end
        step();
        enc_done  = 1'b0;
        req_valid = 2'b01;
        req_data0 = 8'hA1;
        step();
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== 2'b00 || req_ready !== 2'b01) begin
            fails++; $display("FAIL stray_collect: got done=%b ready=%b want 00/01", frame_done, req_ready);
        end
        step();
        enc_done  = 1'b0;
        req_data0 = 8'hA2;
        step();
        req_data0 = 8'hA3;
        step();
        req_valid = 2'b00;
        enc_done  = 1'b1;
        #1;
        tests_run++;
        if (enc_start !== 1'b1 || enc_msg !== 24'hA1A2A3 || frame_done !== 2'b00) begin
            fails++; $display("FAIL stray_launch: got start=%b msg=%h done=%b want 1/a1a2a3/00", enc_start, enc_msg, frame_done);
        end
        step();
        enc_done = 1'b0;
        #1;
        tests_run++;
        if (enc_start !== 1'b0 || frame_done !== 2'b00) begin
            fails++; $display("FAIL stray_wait_entry: got start=%b done=%b want 0/00", enc_start, frame_done);
        end
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== 2'b01) begin fails++; $display("FAIL stray_real_done: got %b want 01", frame_done); end
        step();
        enc_done = 1'b0;
        $display("[TB] stray enc_done ignored");
    endtask

    task automatic test_midframe_reset();
        req_valid = 2'b10;
        req_data1 = 8'h77;
        step();
        step();
        req_data1 = 8'h88;
        step();
        req_data1 = 8'h99;
        step();
        req_valid = 2'b00;
        #1;
        tests_run++;
        if (enc_start !== 1'b1 || enc_id !== 1'b1) begin
            fails++; $display("FAIL mreset_launch: got start=%b id=%b want 1/1", enc_start, enc_id);
        end
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== 2'b00 || frame_abort !== 2'b00 || enc_start !== 1'b0 || req_ready !== 2'b00) begin
            fails++; $display("FAIL mreset_pulses: got done=%b abort=%b start=%b ready=%b want all 0",
                              frame_done, frame_abort, enc_start, req_ready);
        end
        tests_run++;
        if (enc_msg !== 24'h0 || enc_id !== 1'b0) begin
            fails++; $display("FAIL mreset_msg: got msg=%h id=%b want 000000/0", enc_msg, enc_id);
        end
        step();
        enc_done = 1'b0;
        do_frame(1'b1, 24'h123456, 1'b0);
        $display("[TB] mid-frame reset then frame 123456 from requester 1");
    endtask

    task automatic test_stall();
        req_valid = 2'b01;
        req_data0 = 8'hC1;
        step();
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (req_ready !== 2'b00 || frame_abort !== 2'b00) begin
                fails++; $display("FAIL stall_gap%0d: got ready=%b abort=%b want 00/00", i, req_ready, frame_abort);
            end
            step();
        end
        req_valid = 2'b01;
        req_data0 = 8'hC2;
        step();
        req_data0 = 8'hC3;
        step();
        req_valid = 2'b00;
        #1;
        tests_run++;
        if (enc_start !== 1'b1 || enc_msg !== 24'hC1C2C3 || frame_abort !== 2'b00) begin
            fails++; $display("FAIL stall_launch: got start=%b msg=%h abort=%b want 1/c1c2c3/00", enc_start, enc_msg, frame_abort);
        end
        step();
        enc_done = 1'b1;
        #1;
        tests_run++;
        if (frame_done !== 2'b01) begin fails++; $display("FAIL stall_done: got %b want 01", frame_done); end
        step();
        enc_done = 1'b0;
        $display("[TB] stalled frame C1C2C3 completed");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_stray_done();
        test_midframe_reset();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
